// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings and the receiver state enum.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE0 = 2'b00;
    localparam logic [1:0] PARITY_ODD   = 2'b01;
    localparam logic [1:0] PARITY_EVEN  = 2'b10;
    localparam logic [1:0] PARITY_NONE1 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic logic parity_enabled(input logic [1:0] ptype);
        return (ptype == PARITY_ODD) || (ptype == PARITY_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_async,
    output logic rx_sync
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '1;
        else        chain <= {chain[SYNC_STAGES-2:0], rx_async};
    end

    assign rx_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start detection, mid-bit sampling, parity/stop checking.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clock,
    input  logic       ResetN,
    input  logic       BaudTick,
    input  logic       RxIn,
    input  logic [1:0] ParityType,
    input  logic       StopBits,
    input  logic       DataLength,
    output logic [7:0] DataOut,
    output logic       DoneFlag,
    output logic       ParityError,
    output logic       StopError,
    output logic       Active
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    rx_state_e   state, state_nxt;
    logic        rxs;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [1:0]  par_cfg;
    logic        stop2, len8;
    logic        perr, serr;
    logic        armed;

    logic start_det, mid, ctr, last_data, last_stop, confirm, done_set;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (Clock),
        .rst_n    (ResetN),
        .rx_async (RxIn),
        .rx_sync  (rxs)
    );

    // armed blocks a held-low (break) line from retriggering a start right after a frame
    assign start_det = (state == IDLE) && BaudTick && armed && !rxs;
    assign mid       = BaudTick && (cnt == HALF);
    assign ctr       = BaudTick && (cnt == LAST);
    assign last_data = (bit_idx == (len8 ? 3'd7 : 3'd6));
    assign last_stop = !stop2 || (bit_idx == 3'd1);
    assign confirm   = (state == START) && mid && !rxs;
    assign done_set  = (state == STOP) && ctr && last_stop;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_det) state_nxt = START;
            START:   if (mid) state_nxt = rxs ? IDLE : DATA;
            DATA:    if (ctr && last_data) state_nxt = parity_enabled(par_cfg) ? PARITY : STOP;
            PARITY:  if (ctr) state_nxt = STOP;
            STOP:    if (ctr && last_stop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tick counter restarts at the start-bit midpoint so later samples land at bit centres
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            cnt <= '0;
        end else if (state == IDLE || confirm) begin
            cnt <= '0;
        end else if (BaudTick) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            bit_idx     <= '0;
            shreg       <= '0;
            par_cfg     <= PARITY_NONE0;
            stop2       <= 1'b0;
            len8        <= 1'b0;
            perr        <= 1'b0;
            serr        <= 1'b0;
            armed       <= 1'b1;
            DataOut     <= '0;
            DoneFlag    <= 1'b0;
            ParityError <= 1'b0;
            StopError   <= 1'b0;
            Active      <= 1'b0;
        end else begin
            DoneFlag <= 1'b0;
            if (done_set && !rxs) armed <= 1'b0;
            else if (rxs)         armed <= 1'b1;

            if (start_det) begin
                par_cfg <= ParityType;
                stop2   <= StopBits;
                len8    <= DataLength;
                shreg   <= '0;
                perr    <= 1'b0;
                serr    <= 1'b0;
            end
            if (confirm) begin
                Active  <= 1'b1;
                bit_idx <= '0;
            end
            if (ctr) begin
                case (state)
                    DATA: begin
                        shreg[bit_idx] <= rxs;
                        bit_idx        <= last_data ? 3'd0 : bit_idx + 3'd1;
                    end
                    PARITY: begin
                        perr    <= ((^shreg) ^ rxs) != (par_cfg == PARITY_ODD);
                        bit_idx <= '0;
                    end
                    STOP: begin
                        serr    <= serr | !rxs;
                        bit_idx <= bit_idx + 3'd1;
                    end
                    default: ;
                endcase
            end
            if (done_set) begin
                DoneFlag    <= 1'b1;
                DataOut     <= shreg;
                ParityError <= perr;
                StopError   <= serr | !rxs;
                Active      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: bit-accurate line driver, DoneFlag monitor, hand-computed expectations.
module tb_uart_rx_deframer;

    localparam int BIT_CLKS = 64;  // 16 ticks x 4 clocks

    logic       Clock = 1'b0;
    logic       ResetN = 1'b0;
    logic       BaudTick = 1'b0;
    logic       RxIn = 1'b1;
    logic [1:0] ParityType = 2'b00;
    logic       StopBits = 1'b0;
    logic       DataLength = 1'b1;
    logic [7:0] DataOut;
    logic       DoneFlag, ParityError, StopError, Active;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] cap_d[$];
    logic       cap_p[$];
    logic       cap_s[$];
    logic       act_seen = 1'b0;

    uart_rx_deframer #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .Clock(Clock), .ResetN(ResetN), .BaudTick(BaudTick), .RxIn(RxIn),
        .ParityType(ParityType), .StopBits(StopBits), .DataLength(DataLength),
        .DataOut(DataOut), .DoneFlag(DoneFlag), .ParityError(ParityError),
        .StopError(StopError), .Active(Active)
    );

    always #5 Clock = ~Clock;

    initial begin
        int div = 0;
        forever begin
            @(negedge Clock);
            BaudTick = (div == 3);
            div = (div + 1) % 4;
        end
    end

    initial begin
        forever begin
            @(negedge Clock);
            if (DoneFlag) begin
                cap_d.push_back(DataOut);
                cap_p.push_back(ParityError);
                cap_s.push_back(StopError);
            end
            if (Active) act_seen = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        RxIn = b;
        repeat (BIT_CLKS) @(negedge Clock);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    // par: 0 none, 1 odd, 2 even
    task automatic send_frame(input logic [7:0] d, input int nbits, input int par,
                              input logic flip, input int nstop, input logic stop_val);
        logic [7:0] dm;
        logic       p;
        dm = (nbits == 7) ? (d & 8'h7f) : d;
        p  = (par == 1) ? ~(^dm) : (^dm);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(dm[i]);
        if (par != 0) drive_bit(p ^ flip);
        for (int i = 0; i < nstop; i++) drive_bit(stop_val);
    endtask

    task automatic clear_caps();
        cap_d.delete();
        cap_p.delete();
        cap_s.delete();
        act_seen = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input int idx, input logic [7:0] d,
                             input logic p, input logic s);
        if (idx < cap_d.size()) begin
            chk({tag, "_data"}, 32'(cap_d[idx]), 32'(d));
            chk({tag, "_perr"}, 32'(cap_p[idx]), 32'(p));
            chk({tag, "_serr"}, 32'(cap_s[idx]), 32'(s));
        end else begin
            chk({tag, "_present"}, 32'(cap_d.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        repeat (3) @(negedge Clock);
        chk("rst_data", 32'(DataOut), 32'h0);
        chk("rst_done", 32'(DoneFlag), 32'h0);
        chk("rst_perr", 32'(ParityError), 32'h0);
        chk("rst_serr", 32'(StopError), 32'h0);
        chk("rst_active", 32'(Active), 32'h0);
        ResetN = 1'b1;
        idle_bits(2);

        // 1) 8N1 0xA5
        clear_caps();
        ParityType = 2'b00; StopBits = 1'b0; DataLength = 1'b1;
        send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1);
        idle_bits(2);
        chk("t1_count", 32'(cap_d.size()), 32'd1);
        chk_frame("t1", 0, 8'hA5, 1'b0, 1'b0);
        chk("t1_active_seen", 32'(act_seen), 32'd1);
        chk("t1_active_after", 32'(Active), 32'd0);

        // 2) 7E2 0x41, then flipped parity; config changed mid-frame must not matter
        clear_caps();
        ParityType = 2'b10; StopBits = 1'b1; DataLength = 1'b0;
        fork
            send_frame(8'h41, 7, 2, 1'b0, 2, 1'b1);
            begin
                repeat (3 * BIT_CLKS) @(negedge Clock);
                DataLength = 1'b1; ParityType = 2'b00;
            end
        join
        idle_bits(1);
        ParityType = 2'b10; DataLength = 1'b0;
        send_frame(8'h41, 7, 2, 1'b1, 2, 1'b1);
        idle_bits(2);
        chk("t2_count", 32'(cap_d.size()), 32'd2);
        chk_frame("t2a", 0, 8'h41, 1'b0, 1'b0);
        chk_frame("t2b", 1, 8'h41, 1'b1, 1'b0);

        // 3) 8O1 0x00 with low stop bit, then clean 0xFF
        clear_caps();
        ParityType = 2'b01; StopBits = 1'b0; DataLength = 1'b1;
        send_frame(8'h00, 8, 1, 1'b0, 1, 1'b0);
        idle_bits(2);
        chk("t3_count_brk", 32'(cap_d.size()), 32'd1);
        chk_frame("t3a", 0, 8'h00, 1'b0, 1'b1);
        chk("t3_active_after", 32'(Active), 32'd0);
        send_frame(8'hFF, 8, 1, 1'b0, 1, 1'b1);
        idle_bits(2);
        chk("t3_count", 32'(cap_d.size()), 32'd2);
        chk_frame("t3b", 1, 8'hFF, 1'b0, 1'b0);

        // 4) 4-tick glitch, then 0x3C 8N1
        clear_caps();
        ParityType = 2'b00; StopBits = 1'b0; DataLength = 1'b1;
        RxIn = 1'b0;
        repeat (16) @(negedge Clock);
        RxIn = 1'b1;
        idle_bits(2);
        chk("t4_glitch_active", 32'(act_seen), 32'd0);
        chk("t4_glitch_done", 32'(cap_d.size()), 32'd0);
        send_frame(8'h3C, 8, 0, 1'b0, 1, 1'b1);
        idle_bits(2);
        chk("t4_count", 32'(cap_d.size()), 32'd1);
        chk_frame("t4", 0, 8'h3C, 1'b0, 1'b0);

        // 5) back-to-back 0x55, 0xAA
        clear_caps();
        send_frame(8'h55, 8, 0, 1'b0, 1, 1'b1);
        send_frame(8'hAA, 8, 0, 1'b0, 1, 1'b1);
        idle_bits(2);
        chk("t5_count", 32'(cap_d.size()), 32'd2);
        chk_frame("t5a", 0, 8'h55, 1'b0, 1'b0);
        chk_frame("t5b", 1, 8'hAA, 1'b0, 1'b0);

        // 6) async reset mid-DATA, then 0x12
        clear_caps();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        chk("t6_active_pre", 32'(Active), 32'd1);
        chk("t6_data_pre", 32'(DataOut), 32'hAA);
        #2 ResetN = 1'b0;
        #1;
        chk("t6_rst_data", 32'(DataOut), 32'h0);
        chk("t6_rst_done", 32'(DoneFlag), 32'h0);
        chk("t6_rst_perr", 32'(ParityError), 32'h0);
        chk("t6_rst_serr", 32'(StopError), 32'h0);
        chk("t6_rst_active", 32'(Active), 32'h0);
        RxIn = 1'b1;
        repeat (5) @(negedge Clock);
        ResetN = 1'b1;
        idle_bits(2);
        chk("t6_no_partial", 32'(cap_d.size()), 32'd0);
        send_frame(8'h12, 8, 0, 1'b0, 1, 1'b1);
        idle_bits(2);
        chk("t6_count", 32'(cap_d.size()), 32'd1);
        chk_frame("t6", 0, 8'h12, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
